signed_bin_to_7seg_multi: RTL

Parametrised signed two's-complement to multi-digit seven-segment driver. Converts a WIDTH-bit signed word into a sign glyph plus DIGITS decimal digits, driven in parallel on active-low board segment displays. Conversion is sequential: one shift-add-3 step per clock, with a load/busy/done handshake. The displayed value holds until the next conversion completes. Sits between datapath result registers and the board segment pins.

---
 rtl/signed_bin_to_7seg_multi.sv | 123 ++++++++++++
 1 files changed

// File: rtl/signed_bin_to_7seg_multi.sv
// Signed two's-complement to multi-digit active-low seven-segment driver using a sequential shift-add-3 conversion.
// Optional macro LEADING_ZERO_BLANK_EN blanks the digits above the most significant nonzero digit.
module signed_bin_to_7seg_multi #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [WIDTH-1:0]      din,
  input  logic                  load,
  output logic                  busy,
  output logic                  done,
  output logic [7*DIGITS-1:0]   seg_n,
  output logic [6:0]            sign_n
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [6:0] GLYPH_ZERO  = 7'b0000001;
  localparam logic [6:0] GLYPH_MINUS = 7'b1111110;
  localparam logic [6:0] GLYPH_BLANK = 7'b1111111;
`ifdef LEADING_ZERO_BLANK_EN
  localparam bit LZ_BLANK = 1'b1;
`else
  localparam bit LZ_BLANK = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, CONVERT, UPDATE} state_t;

  function automatic logic [6:0] glyph(input logic [3:0] nib);
    case (nib)
      4'd0:    glyph = 7'b0000001;
      4'd1:    glyph = 7'b1001111;
      4'd2:    glyph = 7'b0010010;
      4'd3:    glyph = 7'b0000110;
      4'd4:    glyph = 7'b1001100;
      4'd5:    glyph = 7'b0100100;
      4'd6:    glyph = 7'b0100000;
      4'd7:    glyph = 7'b0001111;
      4'd8:    glyph = 7'b0000000;
      4'd9:    glyph = 7'b0000100;
      default: glyph = GLYPH_BLANK;
    endcase
  endfunction

  // Power-up display: a single "0", with the upper digits blank when blanking is enabled.
  function automatic logic [7*DIGITS-1:0] reset_seg();
    logic [7*DIGITS-1:0] r;
    r = '0;
    for (int i = 0; i < DIGITS; i++)
      r[7*i +: 7] = (i == 0 || !LZ_BLANK) ? GLYPH_ZERO : GLYPH_BLANK;
    return r;
  endfunction

  state_t           state_reg;
  logic [WIDTH-1:0] mag_reg;
  logic [BW-1:0]    bcd_reg;
  logic [CW-1:0]    cnt_reg;
  logic             neg_reg;
  logic [BW-1:0]    bcd_adj;
  logic [7*DIGITS-1:0] seg_dec;

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
      assign bcd_adj[4*gi +: 4] = (bcd_reg[4*gi +: 4] >= 4'd5) ?
                                  bcd_reg[4*gi +: 4] + 4'd3 : bcd_reg[4*gi +: 4];
    end
  endgenerate

  // Scan from the top digit down; a digit is shown once any digit at or above it is nonzero.
  always_comb begin
    logic keep;
    keep    = 1'b0;
    seg_dec = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      keep = keep | (bcd_reg[4*i +: 4] != 4'd0) | (i == 0);
      seg_dec[7*i +: 7] = (LZ_BLANK && !keep) ? GLYPH_BLANK : glyph(bcd_reg[4*i +: 4]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      mag_reg   <= '0;
      bcd_reg   <= '0;
      cnt_reg   <= '0;
      neg_reg   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      seg_n     <= reset_seg();
      sign_n    <= GLYPH_BLANK;
    end else begin
      done <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (load) begin
            neg_reg   <= din[WIDTH-1] & (|din);
            mag_reg   <= din[WIDTH-1] ? (~din + WIDTH'(1)) : din;
            bcd_reg   <= '0;
            cnt_reg   <= '0;
            busy      <= 1'b1;
            state_reg <= CONVERT;
          end
        end
        CONVERT: begin
          {bcd_reg, mag_reg} <= {bcd_adj[BW-2:0], mag_reg, 1'b0};
          cnt_reg <= cnt_reg + CW'(1);
          if (cnt_reg == CW'(WIDTH - 1))
            state_reg <= UPDATE;
        end
        UPDATE: begin
          seg_n     <= seg_dec;
          sign_n    <= neg_reg ? GLYPH_MINUS : GLYPH_BLANK;
          done      <= 1'b1;
          busy      <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
